// File: rtl/sysid_pkg.sv
// Shared definitions for the extended system-identification slave.
// Contents: data width, word-address map, CAPS bit positions and a helper
// that assembles the CAPS word.
package sysid_pkg;

  localparam int SYSID_DW = 32;

  // Word-address map (address is a 3-bit word index)
  localparam logic [2:0] SYSID_ADDR_ID      = 3'd0;
  localparam logic [2:0] SYSID_ADDR_TS      = 3'd1;
  localparam logic [2:0] SYSID_ADDR_UP_LO   = 3'd2;
  localparam logic [2:0] SYSID_ADDR_UP_HI   = 3'd3;
  localparam logic [2:0] SYSID_ADDR_SCRATCH = 3'd4;
  localparam logic [2:0] SYSID_ADDR_CAPS    = 3'd5;

  // CAPS bit positions
  localparam int SYSID_CAPS_UPTIME_BIT = 0;
  localparam int SYSID_CAPS_LAT_LSB    = 4;

  function automatic logic [SYSID_DW-1:0] sysid_caps(input logic       uptime,
                                                     input logic [1:0] lat);
    logic [SYSID_DW-1:0] c;
    c = '0;
    c[SYSID_CAPS_UPTIME_BIT]                    = uptime;
    c[SYSID_CAPS_LAT_LSB+1:SYSID_CAPS_LAT_LSB] = lat;
    return c;
  endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// Read-return pipeline: DEPTH-stage valid/data shift register.
// Ports:
//   clock, reset_n : clock, async active-low reset (flushes all stages)
//   i_vld, i_data  : read accepted this cycle and its sampled data
//   o_vld, o_data  : registered return strobe/data, DEPTH cycles later
// Data stages carry 0 alongside an empty slot, so o_data is 0 whenever
// o_vld is 0 without any output gating.
module sysid_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  logic [DEPTH-1:0]         r_vld_pipe;
  logic [DEPTH-1:0][DW-1:0] r_dat_pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= i_vld;
      r_dat_pipe[0] <= i_vld ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_dat_pipe[i] <= r_dat_pipe[i-1];
      end
    end
  end

  assign o_vld  = r_vld_pipe[DEPTH-1];
  assign o_data = r_dat_pipe[DEPTH-1];

endmodule

// File: rtl/nios_system_sysid_ext.sv
// Avalon-MM system-identification slave (no waitrequest, fixed read latency).
// Word map: 0 ID, 1 TIMESTAMP, 2 UPTIME_LO, 3 UPTIME_HI_SNAP, 4 SCRATCH (RW),
//           5 CAPS, 6-7 read 0.
// Ports: clock/reset_n (async active-low), address[2:0], read, write,
//        writedata[31:0], byteenable[3:0], readdata[31:0], readdatavalid.
// Build option: define SYSID_UPTIME_EN to build the 64-bit uptime counter
// and its high-word snapshot; otherwise words 2/3 read 0 and CAPS bit0=0.
module nios_system_sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID     = 32'h583E_4CC7,
  parameter logic [31:0] TIMESTAMP     = 32'd0,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] SCRATCH_RESET = 32'd0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [2:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [SYSID_DW-1:0] writedata,
  input  logic [3:0]          byteenable,
  output logic [SYSID_DW-1:0] readdata,
  output logic                readdatavalid
);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [1:0]          LAT2  = 2'(READ_LATENCY);
  localparam logic [SYSID_DW-1:0] CAPS  = sysid_caps(UPTIME_PRESENT, LAT2);

  logic [SYSID_DW-1:0] r_scratch;
  logic [SYSID_DW-1:0] w_up_lo;
  logic [SYSID_DW-1:0] w_up_snap;
  logic [SYSID_DW-1:0] w_rdata;

  // Scratch: per-byte writes; writes to any other word are silently dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= SCRATCH_RESET;
    end else if (write && address == SYSID_ADDR_SCRATCH) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) r_scratch[8*b +: 8] <= writedata[8*b +: 8];
    end
  end

`ifdef SYSID_UPTIME_EN
  logic [63:0]         r_uptime;
  logic [SYSID_DW-1:0] r_snap;

  // Reading the low word latches the matching high word, so a following
  // word-3 read sees a consistent 64-bit value even across a carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_uptime <= '0;
      r_snap   <= '0;
    end else begin
      r_uptime <= r_uptime + 64'd1;
      if (read && address == SYSID_ADDR_UP_LO) r_snap <= r_uptime[63:32];
    end
  end

  assign w_up_lo   = r_uptime[31:0];
  assign w_up_snap = r_snap;
`else
  assign w_up_lo   = '0;
  assign w_up_snap = '0;
`endif

  // Read decode samples current state, so a simultaneous write to SCRATCH
  // returns the pre-write value.
  always_comb begin
    w_rdata = '0;
    case (address)
      SYSID_ADDR_ID:      w_rdata = SYSTEM_ID;
      SYSID_ADDR_TS:      w_rdata = TIMESTAMP;
      SYSID_ADDR_UP_LO:   w_rdata = w_up_lo;
      SYSID_ADDR_UP_HI:   w_rdata = w_up_snap;
      SYSID_ADDR_SCRATCH: w_rdata = r_scratch;
      SYSID_ADDR_CAPS:    w_rdata = CAPS;
      default:            w_rdata = '0;
    endcase
  end

  sysid_rd_pipe #(
    .DEPTH (READ_LATENCY),
    .DW    (SYSID_DW)
  ) u_rd_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .i_vld   (read),
    .i_data  (w_rdata),
    .o_vld   (readdatavalid),
    .o_data  (readdata)
  );

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Self-checking bench for nios_system_sysid_ext (READ_LATENCY=2).
// Expected read data is queued with its due cycle when a read is accepted
// and checked by a negedge monitor when readdatavalid appears.
module tb_nios_system_sysid_ext;

  localparam int          LAT   = 2;
  localparam logic [31:0] ID    = 32'h583E_4CC7;
  localparam logic [31:0] TS    = 32'h6512_3456;
  localparam logic [31:0] SRST  = 32'd0;
`ifdef SYSID_UPTIME_EN
  localparam bit          UPT   = 1'b1;
`else
  localparam bit          UPT   = 1'b0;
`endif
  localparam logic [31:0] CAPS_EXP = UPT ? 32'h21 : 32'h20;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  nios_system_sysid_ext #(
    .SYSTEM_ID(ID), .TIMESTAMP(TS), .READ_LATENCY(LAT), .SCRATCH_RESET(SRST)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [63:0] m_up;   // reference uptime model

  always @(posedge clock) cyc++;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) m_up <= '0; else m_up <= m_up + 64'd1;

  typedef struct {
    logic [31:0] exp;
    int          due;
    string       name;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard on its due cycle
  always @(negedge clock) begin
    if (readdatavalid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: readdata %h with nothing outstanding", readdata);
      end else begin
        e = sb.pop_front();
        if (readdata !== e.exp || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: readdata %h at cycle %0d, expected %h at cycle %0d",
                   e.name, readdata, cyc, e.exp, e.due);
        end
      end
    end else if (readdata !== 32'd0) begin
      n_chk++; n_fail++;
      $display("FAIL idle_data: readdata %h while readdatavalid=0", readdata);
    end
  end

  // One bus cycle; call at posedge+1 (or any time before the next edge)
  task automatic op(input bit wr, input bit rd, input logic [2:0] a,
                    input logic [31:0] wd, input logic [3:0] be,
                    input logic [31:0] exp, input string name);
    sb_t s;
    write = wr; read = rd; address = a; writedata = wd; byteenable = be;
    @(posedge clock); #1;
    if (rd) begin
      s.exp = exp; s.due = cyc + LAT - 1; s.name = name;
      sb.push_back(s);
    end
    write = 1'b0; read = 1'b0;
  endtask

  task automatic rd_up(input logic [2:0] a, input string name);
    // word 2 returns counter at accept; m_up has already advanced by the +1
    write = 1'b0; read = 1'b1; address = a;
    @(posedge clock); #1;
    begin
      sb_t s;
      s.exp = UPT ? 32'(m_up - 64'd1) : 32'd0;
      s.due = cyc + LAT - 1; s.name = name;
      sb.push_back(s);
    end
    read = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (LAT + 2) @(negedge clock);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d reads never returned (actual) vs 0 (required)", name, sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[13];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{0, 1, 3'd0, 32'h0,         4'h0, ID,            "rd_id"};
    vt[1]  = '{0, 1, 3'd1, 32'h0,         4'h0, TS,            "rd_ts"};
    vt[2]  = '{0, 1, 3'd5, 32'h0,         4'h0, CAPS_EXP,      "rd_caps"};
    vt[3]  = '{0, 1, 3'd4, 32'h0,         4'h0, SRST,          "rd_scratch_rst"};
    vt[4]  = '{0, 1, 3'd3, 32'h0,         4'h0, 32'h0,         "rd_snap_rst"};
    vt[5]  = '{1, 0, 3'd4, 32'hDEAD_BEEF, 4'h5, 32'h0,         "wr_scratch"};
    vt[6]  = '{0, 1, 3'd4, 32'h0,         4'h0, 32'h00AD_00EF, "rd_scratch_be"};
    vt[7]  = '{1, 0, 3'd0, 32'h1234_5678, 4'hF, 32'h0,         "wr_id"};
    vt[8]  = '{0, 1, 3'd0, 32'h0,         4'h0, ID,            "rd_id_ro"};
    vt[9]  = '{1, 1, 3'd4, 32'h1122_3344, 4'hA, 32'h00AD_00EF, "rdwr_prewrite"};
    vt[10] = '{0, 1, 3'd4, 32'h0,         4'h0, 32'h11AD_33EF, "rd_scratch_post"};
    vt[11] = '{0, 1, 3'd6, 32'h0,         4'h0, 32'h0,         "rd_w6"};
    vt[12] = '{0, 1, 3'd7, 32'h0,         4'h0, 32'h0,         "rd_w7"};

    // Reset state
    #12;
    check("rst_valid", {31'd0, readdatavalid}, 32'd0);
    check("rst_data", readdata, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Table: register map, byte enables, RO writes, read/write collision
    foreach (vt[i])
      op(vt[i].wr, vt[i].rd, vt[i].a, vt[i].wd, vt[i].be, vt[i].exp, vt[i].name);
    drain("table_drain");

    // All 8 words on consecutive cycles
    op(0, 1, 3'd0, 0, 0, ID, "sweep_w0");
    op(0, 1, 3'd1, 0, 0, TS, "sweep_w1");
    rd_up(3'd2, "sweep_w2");
    op(0, 1, 3'd3, 0, 0, 32'd0, "sweep_w3");
    op(0, 1, 3'd4, 0, 0, 32'h11AD_33EF, "sweep_w4");
    op(0, 1, 3'd5, 0, 0, CAPS_EXP, "sweep_w5");
    op(0, 1, 3'd6, 0, 0, 32'd0, "sweep_w6");
    op(0, 1, 3'd7, 0, 0, 32'd0, "sweep_w7");
    drain("sweep_drain");

    // Reset with two reads in flight: both must be discarded
    @(negedge clock);
    op(0, 1, 3'd0, 0, 0, ID, "flight_a");
    op(0, 1, 3'd1, 0, 0, TS, "flight_b");
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("flush_valid", {31'd0, readdatavalid}, 32'd0);
    check("flush_data", readdata, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    op(0, 1, 3'd4, 0, 0, SRST, "post_rst_scratch");
    op(0, 1, 3'd2, 0, 0, UPT ? 32'd1 : 32'd0, "post_rst_uptime");
    op(0, 1, 3'd3, 0, 0, 32'd0, "post_rst_snap");
    drain("post_rst_drain");

`ifdef SYSID_UPTIME_EN
    // Snapshot across a low-word carry
    @(posedge clock); #1;
    force dut.r_uptime = 64'h0000_0001_FFFF_FFFF;
    #1;
    release dut.r_uptime;
    op(0, 1, 3'd2, 0, 0, 32'hFFFF_FFFF, "snap_lo");
    op(0, 1, 3'd3, 0, 0, 32'h0000_0001, "snap_hi");
    drain("snap_drain");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
